inmem_read_sequencer: RTL and testbench
=======================================

// Module: inmem_read_sequencer
// PURPOSE
//  Sequences the matmul-side read port of the 8-bank input memory (port b: unified en/addr, 2048b merged row).
//  On start, streams num_rows consecutive rows from base_addr to the matmul PL over a valid/ready interface.
//  Absorbs BRAM read latency and matmul backpressure with a credit-limited row FIFO; signals done when the last row is consumed.
// PARAMETERS
//  ADDR_W     6     row address width (64 rows per bank)
//  DATA_W     2048  merged row width (8 banks x 256b)
//  RD_LAT     1     cycles from en_b to valid dout_b
//  FIFO_DEPTH 4     row buffer entries; must be >= RD_LAT+2 (elaboration error otherwise)
// PORTS
//  clk_b      in  1        matmul-side clock (same clock as memory port b)
//  rst_n      in  1        asynchronous reset, active low
//  start      in  1        single-cycle pulse; ignored while busy
//  abort      in  1        synchronous flush; returns to IDLE, no done pulse
//  base_addr  in  ADDR_W   first row address, sampled on accepted start
//  num_rows   in  ADDR_W+1 row count, sampled on accepted start; >2^ADDR_W clamps to 2^ADDR_W
//  busy       out 1        high from accepted start until done cycle (exclusive)
//  done       out 1        single-cycle pulse after final row handshake
//  en_b       out 1        drives memory en_b_unified
//  addr_b     out ADDR_W   drives memory addr_b_unified
//  dout_b     in  DATA_W   from memory dout_b_merged
//  row_valid  out 1        FIFO head valid
//  row_ready  in  1        matmul accepts row
//  row_data   out DATA_W   FIFO head data
//  row_last   out 1        qualifies row_valid: final row of the transfer
// BEHAVIOUR
//  - Reset: busy, done, en_b, row_valid, row_last = 0; addr_b = 0; FIFO empty; in-flight reads discarded.
//  - FSM IDLE -> ISSUE on start with clamped num_rows != 0; start with num_rows == 0 -> done pulse next cycle, no reads.
//  - ISSUE: en_b=1 for a cycle iff credits available: (in-flight + FIFO occupancy) < FIFO_DEPTH.
//    addr_b = (base_addr + issued_count) mod 2^ADDR_W (wraps 63 -> 0). ISSUE -> DRAIN after the last read is issued.
//  - DRAIN -> IDLE on handshake (row_valid & row_ready) of the row flagged last; done=1 next cycle, busy=0 that same cycle.
//  - Read return: RD_LAT-deep valid shift register tracks en_b; dout_b written into FIFO in cycle t+RD_LAT
//    for a read issued in cycle t; row_valid earliest at t+RD_LAT+1. Start-to-first-row_valid = RD_LAT+2 cycles.
//  - Throughput: with row_ready held high, one row per cycle sustained after fill.
//  - Credits guarantee FIFO never overflows; no data is dropped under any row_ready pattern.
//  - row_data/row_valid/row_last stable while row_valid & !row_ready.
//  - Simultaneous FIFO write and read in one cycle permitted at any occupancy (incl. full).
//  - abort: highest priority over start and handshakes; next cycle IDLE, FIFO empty, en_b=0, in-flight returns ignored.
//  - start in the done cycle is accepted (IDLE already reached).
//  - Counters: issued/accepted counters ADDR_W+1 bits; no overflow at 64-row transfers.
// STRUCTURE
//  - Shared package inmem_pkg: INMEM_ADDR_W, INMEM_DATA_W, INMEM_RD_LAT, state encoding (IDLE/ISSUE/DRAIN).
//  - One sub-module: inmem_row_fifo (synchronous FIFO, DATA_W+1 wide carrying last flag, count output, FIFO_DEPTH entries).
//  - Top holds FSM, address/issue counter, credit logic, RD_LAT valid pipeline.
// TESTING
//  - Memory model with RD_LAT=1, row k = {256{k[7:0]}}.
//  1 base=0, num=4, ready=1 -> addr_b 0,1,2,3 on consecutive cycles; rows 0..3 in order; row_last on row 3; done once.
//  2 base=62, num=4 -> addr_b 62,63,0,1; data matches; no skipped or repeated address.
//  3 num=64, row_ready random 30% duty -> all 64 rows exactly once, in order; en_b never high when credits=0.
//  4 row_ready=0 for 20 cycles after start, num=8 -> exactly FIFO_DEPTH reads issued, then stall; releases cleanly.
//  5 abort mid-ISSUE (after 3 rows), then start base=10,num=2 -> no done for first job; rows 10,11 only, done once.
//  6 rst_n low mid-DRAIN -> outputs 0 immediately (async); num=0 start -> done next cycle, en_b never asserted.

Source files
------------

// File: rtl/inmem_pkg.sv
// Shared definitions for the input-memory matmul-side read path.
package inmem_pkg;
    localparam int INMEM_ADDR_W     = 6;
    localparam int INMEM_DATA_W     = 2048;
    localparam int INMEM_RD_LAT     = 1;
    localparam int INMEM_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } inmem_state_e;
endpackage

// File: rtl/inmem_row_fifo.sv
// Synchronous row FIFO with occupancy count; concurrent push/pop allowed even when full.
module inmem_row_fifo #(
    parameter int WIDTH = 2049,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full, do_wr, do_rd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o   = (cnt_q == '0);
    assign full      = (cnt_q == CNT_W'(DEPTH));
    assign do_rd     = rd_en_i & ~empty_o;
    assign do_wr     = wr_en_i & (~full | do_rd);
    assign count_o   = cnt_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = do_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({do_wr, do_rd})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Row storage carries no reset: validity lives entirely in the pointers.
    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end
endmodule

// File: rtl/inmem_read_sequencer.sv
// Streams a contiguous run of merged input-memory rows to the matmul over valid/ready,
// issuing BRAM reads only when the row FIFO is guaranteed space for the return.
module inmem_read_sequencer
    import inmem_pkg::*;
#(
    parameter int ADDR_W     = INMEM_ADDR_W,
    parameter int DATA_W     = INMEM_DATA_W,
    parameter int RD_LAT     = INMEM_RD_LAT,
    parameter int FIFO_DEPTH = INMEM_FIFO_DEPTH
) (
    input  logic              clk_b,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_rows,
    output logic              busy,
    output logic              done,
    output logic              en_b,
    output logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] dout_b,
    output logic              row_valid,
    input  logic              row_ready,
    output logic [DATA_W-1:0] row_data,
    output logic              row_last
);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int CR_W   = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;
    localparam logic [CNT_W-1:0] MAX_ROWS = CNT_W'(2 ** ADDR_W);

    if (FIFO_DEPTH < RD_LAT + 2) begin : g_depth_check
        $error("inmem_read_sequencer: FIFO_DEPTH must be at least RD_LAT+2");
    end

    inmem_state_e      state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  num_q, issued_q, num_clamped;
    logic [RD_LAT-1:0] vld_q, last_q;
    logic              done_q, done_d, en_d, start_acc, issue_last, credit_ok, row_hs;
    logic [CR_W-1:0]   inflight;
    logic [FCNT_W-1:0] fifo_cnt;
    logic              fifo_empty, fifo_last;

    assign num_clamped = (num_rows > MAX_ROWS) ? MAX_ROWS : num_rows;
    assign start_acc   = start & (state_q == ST_IDLE) & ~abort;
    assign issue_last  = (issued_q == num_q - CNT_W'(1));
    assign row_hs      = row_valid & row_ready;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CR_W'(vld_q[i]);
        end
    end

    // Reads in flight plus buffered rows must leave room for every return.
    assign credit_ok = (inflight + CR_W'(fifo_cnt)) < CR_W'(FIFO_DEPTH);

    always_comb begin
        state_d = state_q;
        en_d    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (num_clamped != '0) state_d = ST_ISSUE;
                    else                   done_d  = 1'b1;
                end
            end
            ST_ISSUE: begin
                en_d = credit_ok;
                if (credit_ok && issue_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (row_hs && row_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
            en_d    = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            done_q   <= 1'b0;
            base_q   <= '0;
            num_q    <= '0;
            issued_q <= '0;
            vld_q    <= '0;
            last_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (start_acc) begin
                base_q   <= base_addr;
                num_q    <= num_clamped;
                issued_q <= '0;
            end else if (en_d) begin
                issued_q <= issued_q + CNT_W'(1);
            end
            if (abort) begin
                vld_q  <= '0;
                last_q <= '0;
            end else begin
                vld_q[0]  <= en_d;
                last_q[0] <= en_d & issue_last;
                for (int i = 1; i < RD_LAT; i++) begin
                    vld_q[i]  <= vld_q[i-1];
                    last_q[i] <= last_q[i-1];
                end
            end
        end
    end

    inmem_row_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_row_fifo (
        .clk_i     (clk_b),
        .rst_ni    (rst_n),
        .flush_i   (abort),
        .wr_en_i   (vld_q[RD_LAT-1] & ~abort),
        .wr_data_i ({last_q[RD_LAT-1], dout_b}),
        .rd_en_i   (row_ready & ~abort),
        .rd_data_o ({fifo_last, row_data}),
        .empty_o   (fifo_empty),
        .count_o   (fifo_cnt)
    );

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign en_b      = en_d;
    assign addr_b    = base_q + issued_q[ADDR_W-1:0];
    assign row_valid = ~fifo_empty;
    assign row_last  = fifo_last & ~fifo_empty;
endmodule

// File: tb/tb_inmem_read_sequencer.sv
// Bench for inmem_read_sequencer: RD_LAT=1 memory model, row k holds byte k replicated.
module tb_inmem_read_sequencer;
    localparam int FIFO_DEPTH = 4;

    logic          clk_b = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [5:0]    base_addr = '0;
    logic [6:0]    num_rows = '0;
    logic          busy, done, en_b, row_valid, row_last;
    logic          row_ready = 1'b0;
    logic [5:0]    addr_b;
    logic [2047:0] dout_b;
    logic [2047:0] row_data;

    int total = 0;
    int bad = 0;
    int en_total = 0;
    int hs_total = 0;
    int done_cnt = 0;
    int outstanding = 0;
    bit prev_stall = 1'b0;
    logic [2047:0] prev_data;
    logic          prev_last;

    logic [5:0] exp_addr [$];
    logic [6:0] exp_row [$];

    inmem_read_sequencer dut (
        .clk_b     (clk_b),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .num_rows  (num_rows),
        .busy      (busy),
        .done      (done),
        .en_b      (en_b),
        .addr_b    (addr_b),
        .dout_b    (dout_b),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_data  (row_data),
        .row_last  (row_last)
    );

    always #5 clk_b = ~clk_b;

    always @(posedge clk_b) begin
        if (en_b) dout_b <= {256{{2'b00, addr_b}}};
    end

    // Monitor: address order, credit bound, row order/content, hold stability, done count.
    always @(negedge clk_b) begin
        logic [5:0]    a;
        logic [6:0]    e;
        logic [2047:0] ed;
        if (!rst_n || abort) begin
            exp_addr.delete();
            exp_row.delete();
            outstanding = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                total++;
                if (row_valid !== 1'b1 || row_data !== prev_data || row_last !== prev_last) begin
                    bad++;
                    $display("FAIL hold_stable: valid=%b last=%b data_lo=%h required valid=1 last=%b data_lo=%h",
                             row_valid, row_last, row_data[31:0], prev_last, prev_data[31:0]);
                end
            end
            if (en_b === 1'b1) begin
                en_total++;
                total++;
                if (outstanding >= FIFO_DEPTH) begin
                    bad++;
                    $display("FAIL credit: en_b with outstanding=%0d required <%0d", outstanding, FIFO_DEPTH);
                end
                total++;
                if (exp_addr.size() == 0) begin
                    bad++;
                    $display("FAIL addr_b: unexpected read addr=%0d required none", addr_b);
                end else begin
                    a = exp_addr.pop_front();
                    if (addr_b !== a) begin
                        bad++;
                        $display("FAIL addr_b: got %0d required %0d", addr_b, a);
                    end
                end
            end
            if (row_valid === 1'b1 && row_ready === 1'b1) begin
                hs_total++;
                total++;
                if (exp_row.size() == 0) begin
                    bad++;
                    $display("FAIL row: unexpected row data_lo=%h required none", row_data[31:0]);
                end else begin
                    e = exp_row.pop_front();
                    ed = {256{{2'b00, e[5:0]}}};
                    if (row_data !== ed || row_last !== e[6]) begin
                        bad++;
                        $display("FAIL row: data_lo=%h last=%b required data_lo=%h last=%b",
                                 row_data[31:0], row_last, ed[31:0], e[6]);
                    end
                end
            end
            if (done === 1'b1) done_cnt++;
            outstanding = outstanding + ((en_b === 1'b1) ? 1 : 0)
                        - ((row_valid === 1'b1 && row_ready === 1'b1) ? 1 : 0);
            prev_stall = (row_valid === 1'b1 && row_ready !== 1'b1);
            prev_data = row_data;
            prev_last = row_last;
        end
    end

    task automatic start_job(input logic [5:0] b, input logic [6:0] n);
        int cnt;
        cnt = (n > 7'd64) ? 64 : int'(n);
        start = 1'b1;
        base_addr = b;
        num_rows = n;
        for (int k = 0; k < cnt; k++) begin
            exp_addr.push_back(6'(int'(b) + k));
            exp_row.push_back({(k == cnt - 1), 6'(int'(b) + k)});
        end
        @(posedge clk_b);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk_b);
            #1;
            if (done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk_b);
        #1;
        total++;
        if ({busy, done, en_b, row_valid, row_last, addr_b} !== 11'd0) begin
            bad++;
            $display("FAIL reset_outputs: busy=%b done=%b en_b=%b valid=%b last=%b addr=%0d required all 0",
                     busy, done, en_b, row_valid, row_last, addr_b);
        end
        rst_n = 1'b1;
        @(posedge clk_b);
        #1;
    endtask

    task automatic test_basic();
        bit ok;
        int d0;
        d0 = done_cnt;
        row_ready = 1'b1;
        start_job(6'd0, 7'd4);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk_b);
            #1;
            total++;
            if (en_b !== 1'b1 || busy !== 1'b1) begin
                bad++;
                $display("FAIL basic_issue c%0d: en_b=%b busy=%b required 1 1", c, en_b, busy);
            end
            if (c >= 2) begin
                total++;
                if (row_valid !== (c == 3 || c == 4)) begin
                    bad++;
                    $display("FAIL basic_latency c%0d: row_valid=%b required %b", c, row_valid, (c >= 3));
                end
            end
        end
        wait_done(30, ok);
        total++;
        if (!ok || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_done: seen=%b busy=%b required 1 0", ok, busy);
        end
        @(posedge clk_b);
        #1;
        total++;
        if (done !== 1'b0 || done_cnt != d0 + 1 || exp_row.size() != 0) begin
            bad++;
            $display("FAIL basic_single_done: done=%b pulses=%0d left=%0d required 0 1 0",
                     done, done_cnt - d0, exp_row.size());
        end
    endtask

    task automatic test_wrap();
        bit ok;
        int d0;
        d0 = done_cnt;
        row_ready = 1'b1;
        start_job(6'd62, 7'd4);
        wait_done(30, ok);
        @(posedge clk_b);
        #1;
        total++;
        if (!ok || done_cnt != d0 + 1 || exp_row.size() != 0 || exp_addr.size() != 0) begin
            bad++;
            $display("FAIL wrap: done=%b pulses=%0d rows_left=%0d addrs_left=%0d required 1 1 0 0",
                     ok, done_cnt - d0, exp_row.size(), exp_addr.size());
        end
    endtask

    task automatic test_random(input logic [6:0] n);
        bit fin;
        int d0, h0;
        d0 = done_cnt;
        h0 = hs_total;
        fin = 1'b0;
        start_job(6'd17, n);
        for (int i = 0; i < 3000 && !fin; i++) begin
            @(posedge clk_b);
            #1;
            row_ready = ($urandom_range(0, 99) < 30);
            if (done_cnt != d0) fin = 1'b1;
        end
        row_ready = 1'b1;
        total++;
        if (!fin || done_cnt != d0 + 1 || hs_total - h0 != 64 || exp_row.size() != 0) begin
            bad++;
            $display("FAIL random_n%0d: done=%b pulses=%0d rows=%0d left=%0d required 1 1 64 0",
                     n, fin, done_cnt - d0, hs_total - h0, exp_row.size());
        end
        @(posedge clk_b);
        #1;
    endtask

    task automatic test_stall();
        bit ok;
        int d0, e0;
        d0 = done_cnt;
        e0 = en_total;
        row_ready = 1'b0;
        start_job(6'd50, 7'd8);
        repeat (20) @(posedge clk_b);
        #1;
        total++;
        if (en_total - e0 != FIFO_DEPTH || busy !== 1'b1 || row_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall: reads=%0d busy=%b valid=%b required %0d 1 1",
                     en_total - e0, busy, row_valid, FIFO_DEPTH);
        end
        row_ready = 1'b1;
        wait_done(40, ok);
        @(posedge clk_b);
        #1;
        total++;
        if (!ok || en_total - e0 != 8 || done_cnt != d0 + 1 || exp_row.size() != 0) begin
            bad++;
            $display("FAIL stall_release: done=%b reads=%0d pulses=%0d left=%0d required 1 8 1 0",
                     ok, en_total - e0, done_cnt - d0, exp_row.size());
        end
    endtask

    task automatic test_abort();
        bit ok, hit;
        int d0, h0;
        d0 = done_cnt;
        h0 = hs_total;
        hit = 1'b0;
        row_ready = 1'b1;
        start_job(6'd20, 7'd8);
        for (int i = 0; i < 40 && !hit; i++) begin
            @(posedge clk_b);
            #1;
            if (hs_total - h0 >= 3) hit = 1'b1;
        end
        total++;
        if (!hit || busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_setup: rows_seen=%0b busy=%b required 1 1", hit, busy);
        end
        row_ready = 1'b0;
        abort = 1'b1;
        @(posedge clk_b);
        #1;
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || row_valid !== 1'b0 || en_b !== 1'b0) begin
            bad++;
            $display("FAIL abort_flush: busy=%b valid=%b en_b=%b required 0 0 0", busy, row_valid, en_b);
        end
        repeat (4) @(posedge clk_b);
        #1;
        total++;
        if (done_cnt != d0 || row_valid !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_done: pulses=%0d valid=%b required 0 0", done_cnt - d0, row_valid);
        end
        row_ready = 1'b1;
        start_job(6'd10, 7'd2);
        wait_done(30, ok);
        @(posedge clk_b);
        #1;
        total++;
        if (!ok || done_cnt != d0 + 1 || exp_row.size() != 0) begin
            bad++;
            $display("FAIL abort_restart: done=%b pulses=%0d left=%0d required 1 1 0",
                     ok, done_cnt - d0, exp_row.size());
        end
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2;
        int d0;
        d0 = done_cnt;
        row_ready = 1'b1;
        start_job(6'd30, 7'd2);
        wait_done(30, ok1);
        start_job(6'd40, 7'd3);
        wait_done(30, ok2);
        @(posedge clk_b);
        #1;
        total++;
        if (!ok1 || !ok2 || done_cnt != d0 + 2 || exp_row.size() != 0 || exp_addr.size() != 0) begin
            bad++;
            $display("FAIL back_to_back: done1=%b done2=%b pulses=%0d left=%0d required 1 1 2 0",
                     ok1, ok2, done_cnt - d0, exp_row.size());
        end
    endtask

    task automatic test_async_reset_and_empty();
        int d0, e0;
        row_ready = 1'b0;
        start_job(6'd5, 7'd4);
        repeat (10) @(posedge clk_b);
        #1;
        total++;
        if (busy !== 1'b1 || row_valid !== 1'b1) begin
            bad++;
            $display("FAIL drain_setup: busy=%b valid=%b required 1 1", busy, row_valid);
        end
        @(negedge clk_b);
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, en_b, row_valid, row_last, addr_b} !== 11'd0) begin
            bad++;
            $display("FAIL async_reset: busy=%b done=%b en_b=%b valid=%b last=%b addr=%0d required all 0",
                     busy, done, en_b, row_valid, row_last, addr_b);
        end
        repeat (2) @(posedge clk_b);
        #1;
        rst_n = 1'b1;
        @(posedge clk_b);
        #1;
        d0 = done_cnt;
        e0 = en_total;
        start_job(6'd0, 7'd0);
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_rows_done: done=%b busy=%b required 1 0", done, busy);
        end
        repeat (3) @(posedge clk_b);
        #1;
        total++;
        if (done !== 1'b0 || done_cnt != d0 + 1 || en_total != e0 || row_valid !== 1'b0) begin
            bad++;
            $display("FAIL zero_rows_quiet: done=%b pulses=%0d reads=%0d valid=%b required 0 1 0 0",
                     done, done_cnt - d0, en_total - e0, row_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_random(7'd64);
        test_random(7'd100);
        test_stall();
        test_abort();
        test_back_to_back();
        test_async_reset_and_empty();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
